// File: rtl/mem_pkg.sv
// Shared types and default parameters for the MEM-stage SRAM controller.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned DEF_BASE_ADDR   = 1024;
    localparam int unsigned DEF_WAIT_CYCLES = 2;
    localparam int unsigned DEF_SRAM_AW     = 18;
    localparam int unsigned CNT_W           = 4;
    localparam int unsigned HALF_W          = 16;
    localparam int unsigned DATA_W          = 32;

endpackage

// File: rtl/sram_phase_counter.sv
// Loadable phase counter; tc marks the last wait cycle of a half-word phase.
module sram_phase_counter
    import mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    assign tc = (count == CNT_W'(WAIT_CYCLES - 1));

    // Priority: clear, then load, then increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller: 32-bit loads/stores as two 16-bit SRAM phases, low half first.
module mem_stage_sram_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int unsigned SRAM_AW     = DEF_SRAM_AW
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [31:0]         address,
    input  logic [31:0]         write_data,
    output logic [31:0]         read_data,
    output logic                ready,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic [15:0]         sram_dq_out,
    input  logic [15:0]         sram_dq_in,
    output logic                sram_dq_oe,
    output logic                sram_we_n
);

    localparam int unsigned WORD_W = SRAM_AW - 1;

    state_t             state;
    logic               op_write;
    logic [WORD_W-1:0]  word;
    logic [HALF_W-1:0]  data_hi;
    logic [HALF_W-1:0]  lo_reg;
    logic               req;
    logic [WORD_W-1:0]  req_word;
    logic               in_phase;
    logic               phase_tc;
    logic [CNT_W-1:0]   phase_count;

    assign req      = mem_read | mem_write;
    // Out-of-range addresses wrap silently modulo the SRAM word count.
    assign req_word = WORD_W'((address - 32'(BASE_ADDR)) >> 2);
    assign in_phase = (state == LO) || (state == HI);
    assign ready    = (state == DONE) || ((state == IDLE) && !req);

    sram_phase_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_phase_counter (
        .clk        (clock),
        .rst        (reset),
        .clear      (in_phase && phase_tc),
        .load       ((state == IDLE) && req),
        .load_value (CNT_W'(0)),
        .enable     (in_phase),
        .count      (phase_count),
        .tc         (phase_tc)
    );

    // FSM with registered SRAM strobes, set up one edge ahead of each phase.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            op_write    <= 1'b0;
            word        <= '0;
            data_hi     <= '0;
            lo_reg      <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        // Write wins when both request lines are raised.
                        op_write    <= mem_write;
                        word        <= req_word;
                        data_hi     <= write_data[31:16];
                        sram_addr   <= {req_word, 1'b0};
                        sram_dq_out <= write_data[15:0];
                        sram_dq_oe  <= mem_write;
                        sram_we_n   <= !mem_write;
                        state       <= LO;
                    end
                end
                LO: begin
                    if (phase_tc) begin
                        if (!op_write) begin
                            lo_reg <= sram_dq_in;
                        end
                        sram_addr   <= {word, 1'b1};
                        sram_dq_out <= data_hi;
                        state       <= HI;
                    end
                end
                HI: begin
                    if (phase_tc) begin
                        if (!op_write) begin
                            read_data <= {sram_dq_in, lo_reg};
                        end
                        sram_dq_oe <= 1'b0;
                        sram_we_n  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl with a small behavioural SRAM.
module tb_mem_stage_sram_ctrl;

    localparam int unsigned SRAM_AW = 18;

    logic               clock;
    logic               reset;
    logic               mem_read;
    logic               mem_write;
    logic [31:0]        address;
    logic [31:0]        write_data;
    logic [31:0]        read_data;
    logic               ready;
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_dq_out;
    logic [15:0]        sram_dq_in;
    logic               sram_dq_oe;
    logic               sram_we_n;

    int total = 0;
    int bad   = 0;

    logic [15:0] sram_mem [0:63];

    mem_stage_sram_ctrl #(
        .BASE_ADDR   (1024),
        .WAIT_CYCLES (2),
        .SRAM_AW     (SRAM_AW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign sram_dq_in = sram_mem[sram_addr[5:0]];

    always @(posedge clock) begin
        if (sram_we_n === 1'b0) sram_mem[sram_addr[5:0]] <= sram_dq_out;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Cycle 1 = request presentation at a negedge; cycle 6 = DONE, cycle 7 = idle again.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] alt_addr,
                             input logic [31:0] exp_rdata, input logic [SRAM_AW-1:0] exp_base);
        logic               is_wr;
        logic [SRAM_AW-1:0] exp_addr;
        logic [15:0]        exp_dq;
        is_wr      = wr;
        mem_read   = rd;
        mem_write  = wr;
        address    = addr;
        write_data = wd;
        #1;
        check("ready_c1", 32'(ready), 32'd0);
        for (int c = 2; c <= 6; c++) begin
            @(posedge clock);
            @(negedge clock);
            if (c <= 5) address = alt_addr;
            else begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
                address   = 32'd0;
            end
            #1;
            if (c <= 5) begin
                exp_addr = (c >= 4) ? exp_base + SRAM_AW'(1) : exp_base;
                exp_dq   = (c >= 4) ? wd[31:16] : wd[15:0];
                check("ready_busy", 32'(ready), 32'd0);
                check("sram_addr", 32'(sram_addr), 32'(exp_addr));
                check("we_n_busy", 32'(sram_we_n), 32'(!is_wr));
                check("oe_busy", 32'(sram_dq_oe), 32'(is_wr));
                if (is_wr) check("dq_out", 32'(sram_dq_out), 32'(exp_dq));
            end else begin
                check("ready_done", 32'(ready), 32'd1);
                check("we_n_done", 32'(sram_we_n), 32'd1);
                check("oe_done", 32'(sram_dq_oe), 32'd0);
                check("rdata_done", read_data, exp_rdata);
            end
        end
        @(posedge clock);
        @(negedge clock);
        #1;
        check("ready_idle", 32'(ready), 32'd1);
        check("rdata_hold", read_data, exp_rdata);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) sram_mem[i] = 16'h0000;
        reset      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        address    = 32'd0;
        write_data = 32'd0;

        // Reset asserted mid-cycle: outputs must settle immediately.
        #3 reset = 1'b1;
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_rdata", read_data, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("post_rst_ready", 32'(ready), 32'd1);
        check("post_rst_we_n", 32'(sram_we_n), 32'd1);
        check("post_rst_addr", 32'(sram_addr), 32'd0);
        @(negedge clock);

        // Store then load word 2 (half-words 4/5).
        do_access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 32'd1032, 32'h0, 18'd4);
        check("sram_h4", 32'(sram_mem[4]), 32'h0000BEEF);
        check("sram_h5", 32'(sram_mem[5]), 32'h0000DEAD);
        do_access(1'b1, 1'b0, 32'd1032, 32'h0, 32'd1032, 32'hDEADBEEF, 18'd4);

        // Store to word 4; read_data must keep the previous load result.
        do_access(1'b0, 1'b1, 32'd1040, 32'h12345678, 32'd1040, 32'hDEADBEEF, 18'd8);

        // Address wobbles while frozen: access stays on the latched word.
        do_access(1'b1, 1'b0, 32'd1032, 32'h0, 32'd2000, 32'hDEADBEEF, 18'd4);
        do_access(1'b1, 1'b0, 32'd1040, 32'h0, 32'd1040, 32'h12345678, 18'd8);

        // Read and write together behave as a write.
        do_access(1'b1, 1'b1, 32'd1048, 32'hCAFEF00D, 32'd1048, 32'h12345678, 18'd12);
        do_access(1'b1, 1'b0, 32'd1048, 32'h0, 32'd1048, 32'hCAFEF00D, 18'd12);

        // Out-of-range address wraps to word 3 (half-words 6/7).
        do_access(1'b0, 1'b1, 32'd1024 + (32'd4 << 17) + 32'd12, 32'hA5A55A5A,
                  32'd1024 + (32'd4 << 17) + 32'd12, 32'hCAFEF00D, 18'd6);
        do_access(1'b1, 1'b0, 32'd1036, 32'h0, 32'd1036, 32'hA5A55A5A, 18'd6);

        // Reset during the HI phase of a load aborts it.
        mem_read = 1'b1;
        address  = 32'd1040;
        for (int c = 2; c <= 4; c++) begin
            @(posedge clock);
            @(negedge clock);
        end
        #1;
        check("pre_abort_addr", 32'(sram_addr), 32'd9);
        mem_read = 1'b0;
        reset    = 1'b1;
        #1;
        check("abort_we_n", 32'(sram_we_n), 32'd1);
        check("abort_rdata", read_data, 32'd0);
        check("abort_ready", 32'(ready), 32'd1);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        do_access(1'b1, 1'b0, 32'd1040, 32'h0, 32'd1040, 32'h12345678, 18'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
